// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : Cache-side and memory-side bus signals of the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int XLEN = 32
);
    logic [1:0]      icache_command;
    logic [XLEN-1:0] icache_addr;
    logic [1:0]      dcache_command;
    logic [XLEN-1:0] dcache_addr;
    logic [63:0]     dcache_data;
    logic [3:0]      mem2proc_response;
    logic [63:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;
    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;
    logic [3:0]      icache_response;
    logic [3:0]      dcache_response;
    logic [3:0]      icache_tag;
    logic [3:0]      dcache_tag;
    logic [63:0]     ret_data;
    logic [3:0]      i_outstanding;
    logic [3:0]      d_outstanding;
    logic            orphan_tag_err;

    // Arbiter side
    modport slave (
        input  icache_command, icache_addr, dcache_command, dcache_addr,
               dcache_data, mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
               icache_response, dcache_response, icache_tag, dcache_tag,
               ret_data, i_outstanding, d_outstanding, orphan_tag_err
    );

    // Caches plus memory, as seen by whoever drives the arbiter
    modport master (
        output icache_command, icache_addr, dcache_command, dcache_addr,
               dcache_data, mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
               icache_response, dcache_response, icache_tag, dcache_tag,
               ret_data, i_outstanding, d_outstanding, orphan_tag_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : I/D-cache to main-memory arbiter with tag ownership tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int XLEN         = 32,
    parameter int N_TAGS       = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic        clock,
    input  wire logic        reset,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [1:0]       c_BUS_NONE   = 2'd0;
    localparam logic [1:0]       c_BUS_LOAD   = 2'd1;
    localparam int               c_SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_SW-1:0]  c_STARVE_MAX = c_SW'(STARVE_LIMIT);

    logic [N_TAGS:0] r_valid;
    logic [N_TAGS:0] r_owner_d;
    logic [c_SW-1:0] r_starve;
    logic            r_orphan;
    logic [3:0]      r_i_cnt;
    logic [3:0]      r_d_cnt;

    logic            w_i_req;
    logic            w_d_req;
    logic            w_grant_i;
    logic            w_grant_d;
    logic            w_resp_nz;
    logic            w_resp_ok;
    logic            w_rtag_ok;
    logic            w_ret_hit;
    logic            w_ret_owner_d;
    logic            w_alloc;
    logic            w_orphan_set;
    logic [N_TAGS:0] w_valid_nxt;
    logic [N_TAGS:0] w_owner_nxt;
    logic [3:0]      w_i_cnt;
    logic [3:0]      w_d_cnt;

    // Grant: D-cache first unless the I-cache has hit the starvation limit
    assign w_i_req   = (bus.icache_command != c_BUS_NONE);
    assign w_d_req   = (bus.dcache_command != c_BUS_NONE);
    assign w_grant_i = w_i_req && (!w_d_req || (r_starve == c_STARVE_MAX));
    assign w_grant_d = w_d_req && !w_grant_i;

    assign bus.proc2mem_command = w_grant_i ? bus.icache_command :
                                  w_grant_d ? bus.dcache_command : c_BUS_NONE;
    assign bus.proc2mem_addr    = w_grant_i ? bus.icache_addr :
                                  w_grant_d ? bus.dcache_addr : '0;
    assign bus.proc2mem_data    = bus.dcache_data;
    assign bus.icache_response  = w_grant_i ? bus.mem2proc_response : 4'd0;
    assign bus.dcache_response  = w_grant_d ? bus.mem2proc_response : 4'd0;

    assign w_resp_nz = (bus.mem2proc_response != 4'd0);
    assign w_resp_ok = w_resp_nz && (int'(bus.mem2proc_response) <= N_TAGS);
    assign w_rtag_ok = (bus.mem2proc_tag != 4'd0) && (int'(bus.mem2proc_tag) <= N_TAGS);

    assign w_ret_hit     = w_rtag_ok && r_valid[bus.mem2proc_tag];
    assign w_ret_owner_d = r_owner_d[bus.mem2proc_tag];
    assign w_alloc       = (bus.proc2mem_command == c_BUS_LOAD) && w_resp_ok;

    assign bus.icache_tag = (w_ret_hit && !w_ret_owner_d) ? bus.mem2proc_tag : 4'd0;
    assign bus.dcache_tag = (w_ret_hit &&  w_ret_owner_d) ? bus.mem2proc_tag : 4'd0;
    assign bus.ret_data   = bus.mem2proc_data;

    // A load landing on a live entry is a collision unless this same cycle's return frees it
    assign w_orphan_set = ((bus.mem2proc_tag != 4'd0) && !w_ret_hit) ||
                          (w_alloc && r_valid[bus.mem2proc_response] &&
                           !(w_ret_hit && (bus.mem2proc_tag == bus.mem2proc_response)));

    // Return is applied before allocate so a same-cycle reuse ends with the new owner
    always_comb begin
        w_valid_nxt = r_valid;
        w_owner_nxt = r_owner_d;
        if (w_ret_hit) begin
            w_valid_nxt[bus.mem2proc_tag] = 1'b0;
        end
        if (w_alloc) begin
            w_valid_nxt[bus.mem2proc_response] = 1'b1;
            w_owner_nxt[bus.mem2proc_response] = w_grant_d;
        end
        w_valid_nxt[0] = 1'b0;
    end

    always_comb begin
        w_i_cnt = 4'd0;
        w_d_cnt = 4'd0;
        for (int k = 1; k <= N_TAGS; k++) begin
            if (w_valid_nxt[k] && !w_owner_nxt[k]) w_i_cnt = w_i_cnt + 4'd1;
            if (w_valid_nxt[k] &&  w_owner_nxt[k]) w_d_cnt = w_d_cnt + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid   <= '0;
            r_owner_d <= '0;
            r_starve  <= '0;
            r_orphan  <= 1'b0;
            r_i_cnt   <= 4'd0;
            r_d_cnt   <= 4'd0;
        end else begin
            r_valid   <= w_valid_nxt;
            r_owner_d <= w_owner_nxt;
            r_orphan  <= r_orphan | w_orphan_set;
            r_i_cnt   <= w_i_cnt;
            r_d_cnt   <= w_d_cnt;
            if (w_i_req && !(w_grant_i && w_resp_nz)) begin
                if (r_starve != c_STARVE_MAX) r_starve <= r_starve + 1'b1;
            end else begin
                r_starve <= '0;
            end
        end
    end

    assign bus.i_outstanding  = r_i_cnt;
    assign bus.d_outstanding  = r_d_cnt;
    assign bus.orphan_tag_err = r_orphan;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Randomized self-checking bench for mem_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;
    localparam int c_LIMIT = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    // Reference state: who owns each tag, plus the starvation and error history
    bit   m_valid [16];
    bit   m_is_d  [16];
    int   m_starve;
    bit   m_orphan;

    mem_bus_arbiter_if #(.XLEN(32)) bus ();

    mem_bus_arbiter #(
        .XLEN         (32),
        .N_TAGS       (15),
        .STARVE_LIMIT (c_LIMIT)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 16; k++) begin
            m_valid[k] = 1'b0;
            m_is_d[k]  = 1'b0;
        end
        m_starve = 0;
        m_orphan = 1'b0;
    endtask

    task automatic drive(input logic [1:0] icmd, input logic [31:0] iaddr,
                         input logic [1:0] dcmd, input logic [31:0] daddr,
                         input logic [63:0] ddata, input logic [3:0] resp,
                         input logic [63:0] rdata, input logic [3:0] rtag);
        bus.icache_command    = icmd;
        bus.icache_addr       = iaddr;
        bus.dcache_command    = dcmd;
        bus.dcache_addr       = daddr;
        bus.dcache_data       = ddata;
        bus.mem2proc_response = resp;
        bus.mem2proc_data     = rdata;
        bus.mem2proc_tag      = rtag;
    endtask

    // One bus cycle: apply inputs after the falling edge, check, then advance the model
    task automatic step(input logic [1:0] icmd, input logic [31:0] iaddr,
                        input logic [1:0] dcmd, input logic [31:0] daddr,
                        input logic [63:0] ddata, input logic [3:0] resp,
                        input logic [63:0] rdata, input logic [3:0] rtag);
        int          winner;
        int          icnt;
        int          dcnt;
        logic [1:0]  e_cmd;
        logic [31:0] e_addr;
        logic [3:0]  e_itag;
        logic [3:0]  e_dtag;
        @(negedge clk);
        drive(icmd, iaddr, dcmd, daddr, ddata, resp, rdata, rtag);
        #1;
        if (icmd != 2'd0 && m_starve == c_LIMIT) winner = 1;
        else if (dcmd != 2'd0)                   winner = 2;
        else if (icmd != 2'd0)                   winner = 1;
        else                                     winner = 0;
        e_cmd  = (winner == 1) ? icmd  : (winner == 2) ? dcmd  : 2'd0;
        e_addr = (winner == 1) ? iaddr : (winner == 2) ? daddr : 32'd0;
        e_itag = 4'd0;
        e_dtag = 4'd0;
        if (rtag != 4'd0 && m_valid[rtag]) begin
            if (m_is_d[rtag]) e_dtag = rtag;
            else              e_itag = rtag;
        end
        icnt = 0;
        dcnt = 0;
        for (int k = 1; k < 16; k++) begin
            if (m_valid[k] && !m_is_d[k]) icnt++;
            if (m_valid[k] &&  m_is_d[k]) dcnt++;
        end
        chk("cmd",    64'(bus.proc2mem_command), 64'(e_cmd));
        chk("addr",   64'(bus.proc2mem_addr),    64'(e_addr));
        chk("wdata",  bus.proc2mem_data,         ddata);
        chk("iresp",  64'(bus.icache_response),  64'((winner == 1) ? resp : 4'd0));
        chk("dresp",  64'(bus.dcache_response),  64'((winner == 2) ? resp : 4'd0));
        chk("itag",   64'(bus.icache_tag),       64'(e_itag));
        chk("dtag",   64'(bus.dcache_tag),       64'(e_dtag));
        chk("rdata",  bus.ret_data,              rdata);
        chk("i_out",  64'(bus.i_outstanding),    64'(icnt));
        chk("d_out",  64'(bus.d_outstanding),    64'(dcnt));
        chk("orphan", 64'(bus.orphan_tag_err),   64'(m_orphan));
        if (rtag != 4'd0) begin
            if (m_valid[rtag]) m_valid[rtag] = 1'b0;
            else               m_orphan = 1'b1;
        end
        if (e_cmd == 2'd1 && resp != 4'd0) begin
            if (m_valid[resp]) m_orphan = 1'b1;
            m_valid[resp] = 1'b1;
            m_is_d[resp]  = (winner == 2);
        end
        if (icmd != 2'd0 && !(winner == 1 && resp != 4'd0))
            m_starve = (m_starve < c_LIMIT) ? m_starve + 1 : c_LIMIT;
        else
            m_starve = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 64'd0, 4'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_cmd",    64'(bus.proc2mem_command), 64'd0);
        chk("rst_i_out",  64'(bus.i_outstanding),    64'd0);
        chk("rst_d_out",  64'(bus.d_outstanding),    64'd0);
        chk("rst_orphan", 64'(bus.orphan_tag_err),   64'd0);
        chk("rst_itag",   64'(bus.icache_tag),       64'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] pick_valid_tag();
        int cands[$];
        for (int k = 1; k < 16; k++) if (m_valid[k]) cands.push_back(k);
        if (cands.size() == 0) return 4'd0;
        return 4'(cands[$urandom_range(cands.size() - 1)]);
    endfunction

    function automatic logic [3:0] pick_free_tag();
        int cands[$];
        for (int k = 1; k < 16; k++) if (!m_valid[k]) cands.push_back(k);
        if (cands.size() == 0) return 4'd0;
        return 4'(cands[$urandom_range(cands.size() - 1)]);
    endfunction

    task automatic random_cycle();
        logic [1:0] icmd;
        logic [1:0] dcmd;
        logic [3:0] resp;
        logic [3:0] rtag;
        int         r;
        icmd = ($urandom_range(99) < 60) ? 2'd1 : 2'd0;
        r    = $urandom_range(99);
        dcmd = (r < 40) ? 2'd1 : (r < 60) ? 2'd2 : 2'd0;
        r    = $urandom_range(99);
        // Responses mostly go to free tags; occasional reuse exercises the collision path
        if (r < 30)      resp = 4'd0;
        else if (r < 90) resp = pick_free_tag();
        else             resp = 4'($urandom_range(1, 15));
        if (dcmd == 2'd2 && resp != 4'd0 && m_valid[resp]) resp = 4'd0;
        r = $urandom_range(99);
        if (r < 45)      rtag = pick_valid_tag();
        else if (r < 50) rtag = 4'($urandom_range(1, 15));
        else             rtag = 4'd0;
        step(icmd, $urandom, dcmd, $urandom, {$urandom, $urandom}, resp,
             {$urandom, $urandom}, rtag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_clear();
        rst_n = 1'b0;
        drive(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 64'd0, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Both caches load every cycle with fresh tags: I-cache forced through on cycle 4
        for (int c = 0; c < 6; c++)
            step(2'd1, 32'h1000 + c, 2'd1, 32'h2000 + c, 64'hD0 + 64'(c), 4'(c + 1), 64'd0, 4'd0);
        // Out-of-order returns, store with no allocation, then an orphan return
        step(2'd0, 32'd0, 2'd1, 32'h3000, 64'd0, 4'd7, 64'd0, 4'd0);
        step(2'd1, 32'h3100, 2'd0, 32'd0, 64'd0, 4'd8, 64'd0, 4'd0);
        step(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 64'hAA, 4'd8);
        step(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 64'hBB, 4'd7);
        step(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 64'd0, 4'd0);
        // Tag 5 returns to the I-cache while being re-accepted for a D-cache load
        step(2'd0, 32'd0, 2'd1, 32'h4000, 64'd0, 4'd5, 64'hCC, 4'd5);
        step(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 64'd0, 4'd0);
        step(2'd0, 32'd0, 2'd2, 32'h5000, 64'h55, 4'd9, 64'd0, 4'd0);
        step(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 64'd0, 4'd9);
        step(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 64'd0, 4'd0);

        do_reset();
        // Memory refuses the I-cache for 6 cycles, then accepts
        for (int c = 0; c < 6; c++)
            step(2'd1, 32'h6000, 2'd0, 32'd0, 64'd0, 4'd0, 64'd0, 4'd0);
        step(2'd1, 32'h6000, 2'd0, 32'd0, 64'd0, 4'd2, 64'd0, 4'd0);
        step(2'd1, 32'h6000, 2'd1, 32'h7000, 64'd0, 4'd3, 64'd0, 4'd0);
        step(2'd0, 32'd0, 2'd0, 32'd0, 64'd0, 4'd0, 64'd0, 4'd0);

        for (int blk = 0; blk < 4; blk++) begin
            for (int c = 0; c < 150; c++) random_cycle();
            do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
